// File: rtl/tsr_wr_ingress.sv
// Write-bus ingress for the TSR accelerator: splits beats into a weight-memory stream and a ping-pong image frame buffer.
// Optional build macro WR_SEQ_CHECK_EN enforces in-order beat addresses on both paths.
module tsr_wr_ingress #(
    parameter int IMG_WORDS = 384,
    parameter int IMG_AW    = 9,
    parameter int PIX_W     = 24,
    parameter int WGT_BASE  = 3097,
    parameter int WGT_WORDS = 14173,
    parameter int WGT_AW    = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axi_wr_en,
    input  logic [19:0]       axi_wr_addr,
    input  logic [63:0]       axi_wr_data,
    input  logic [7:0]        axi_wr_strobe,
    output logic              wgt_we,
    output logic [WGT_AW-1:0] wgt_addr,
    output logic [63:0]       wgt_data,
    output logic              weight_load_done,
    output logic              frm_valid,
    input  logic              frm_rd_en,
    input  logic [IMG_AW-1:0] frm_rd_addr,
    output logic [PIX_W-1:0]  frm_rd_data,
    input  logic              frm_done,
    output logic              err_drop
);

    localparam int          WGT_CW   = $clog2(WGT_WORDS + 1);
    localparam logic [19:0] WGT_LO   = 20'(WGT_BASE);
    localparam logic [19:0] WGT_HI   = 20'(WGT_BASE + WGT_WORDS);
    localparam logic [19:0] IMG_HI   = 20'(IMG_WORDS);
    localparam logic [IMG_AW-1:0] IMG_LAST = IMG_AW'(IMG_WORDS - 1);
    localparam logic [WGT_CW-1:0] WGT_FULL = WGT_CW'(WGT_WORDS);
    localparam int          MEM_DEPTH = 2 ** (IMG_AW + 1);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_e;

    function automatic logic [63:0] lane_mask(input logic [63:0] data, input logic [7:0] strb);
        logic [63:0] m;
        m = 64'd0;
        for (int k = 0; k < 8; k++) begin
            m[8*k +: 8] = strb[k] ? data[8*k +: 8] : 8'h00;
        end
        return m;
    endfunction

    logic [WGT_CW-1:0] wgt_cnt_q, wgt_cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wgt_we_q;
    logic [WGT_AW-1:0] wgt_addr_q;
    logic [63:0]       wgt_data_q;
    logic [IMG_AW-1:0] img_cnt_q, img_cnt_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    bank_state_e       bank_q [2];
    bank_state_e       bank_d [2];
    logic              frm_valid_q, frm_valid_d;
    logic [PIX_W-1:0]  rd_data_q;
    logic [PIX_W-1:0]  mem [MEM_DEPTH];

    logic              beat_s, in_wgt_s, in_img_s;
    logic              wgt_seq_ok_s, img_seq_ok_s;
    logic              wgt_acc_s, img_acc_s, drop_s;
    logic              wr_bank_free_s, rd_ok_s, frm_rel_s;
    logic [WGT_AW-1:0] wgt_off_s;
    logic [63:0]       masked_s;

    // Beat decode and acceptance; every rejected non-empty beat is a drop.
    always_comb begin
        masked_s  = lane_mask(axi_wr_data, axi_wr_strobe);
        beat_s    = axi_wr_en && (axi_wr_strobe != 8'h00);
        in_wgt_s  = (axi_wr_addr >= WGT_LO) && (axi_wr_addr < WGT_HI);
        in_img_s  = (axi_wr_addr < IMG_HI);
        wgt_off_s = WGT_AW'(axi_wr_addr - WGT_LO);
`ifdef WR_SEQ_CHECK_EN
        wgt_seq_ok_s = done_q || (wgt_off_s == WGT_AW'(wgt_cnt_q));
        img_seq_ok_s = (axi_wr_addr == 20'(img_cnt_q));
`else
        wgt_seq_ok_s = 1'b1;
        img_seq_ok_s = 1'b1;
`endif
        wr_bank_free_s = (bank_q[wr_bank_q] == BANK_EMPTY) || (bank_q[wr_bank_q] == BANK_FILLING);
        wgt_acc_s = beat_s && in_wgt_s && wgt_seq_ok_s;
        img_acc_s = beat_s && in_img_s && done_q && wr_bank_free_s && img_seq_ok_s;
        drop_s    = beat_s && !wgt_acc_s && !img_acc_s;
    end

    // Weight counter saturates at the full load so reloads never wrap it.
    always_comb begin
        wgt_cnt_d = wgt_cnt_q;
        if (wgt_acc_s && (wgt_cnt_q != WGT_FULL)) begin
            wgt_cnt_d = wgt_cnt_q + WGT_CW'(1);
        end else begin
            wgt_cnt_d = wgt_cnt_q;
        end
        done_d = done_q || (wgt_cnt_q == WGT_FULL);
        err_d  = err_q || drop_s;
    end

    // Bank state machine: read side and write side never touch the same bank in one cycle.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        img_cnt_d = img_cnt_q;
        rd_ok_s   = (bank_q[rd_bank_q] == BANK_FULL) || (bank_q[rd_bank_q] == BANK_READING);
        frm_rel_s = frm_done && rd_ok_s;

        if (frm_rel_s) begin
            bank_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d         = ~rd_bank_q;
        end else if (bank_q[rd_bank_q] == BANK_FULL) begin
            bank_d[rd_bank_q] = BANK_READING;
        end else begin
            bank_d[rd_bank_q] = bank_q[rd_bank_q];
        end

        if (img_acc_s) begin
            if (img_cnt_q == IMG_LAST) begin
                bank_d[wr_bank_q] = BANK_FULL;
                img_cnt_d         = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                bank_d[wr_bank_q] = BANK_FILLING;
                img_cnt_d         = img_cnt_q + IMG_AW'(1);
            end
        end else begin
            img_cnt_d = img_cnt_q;
        end

        frm_valid_d = (bank_d[rd_bank_d] == BANK_FULL) || (bank_d[rd_bank_d] == BANK_READING);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wgt_cnt_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wgt_we_q    <= 1'b0;
            wgt_addr_q  <= '0;
            wgt_data_q  <= 64'd0;
            img_cnt_q   <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_q[0]   <= BANK_EMPTY;
            bank_q[1]   <= BANK_EMPTY;
            frm_valid_q <= 1'b0;
        end else begin
            wgt_cnt_q   <= wgt_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wgt_we_q    <= wgt_acc_s;
            wgt_addr_q  <= wgt_acc_s ? wgt_off_s : wgt_addr_q;
            wgt_data_q  <= wgt_acc_s ? masked_s : wgt_data_q;
            img_cnt_q   <= img_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_q[0]   <= bank_d[0];
            bank_q[1]   <= bank_d[1];
            frm_valid_q <= frm_valid_d;
        end
    end

    // Frame buffer write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (img_acc_s) begin
            mem[{wr_bank_q, axi_wr_addr[IMG_AW-1:0]}] <= masked_s[PIX_W-1:0];
        end
    end

    // Frame buffer read port, one-cycle latency from the current read bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (frm_rd_en) begin
            rd_data_q <= mem[{rd_bank_q, frm_rd_addr}];
        end else begin
            rd_data_q <= rd_data_q;
        end
    end

    assign wgt_we           = wgt_we_q;
    assign wgt_addr         = wgt_addr_q;
    assign wgt_data         = wgt_data_q;
    assign weight_load_done = done_q;
    assign frm_valid        = frm_valid_q;
    assign frm_rd_data      = rd_data_q;
    assign err_drop         = err_q;

endmodule

// File: tb/tb_tsr_wr_ingress.sv
// Scoreboard bench for tsr_wr_ingress: weight beats and frame reads are queued at drive time and checked on output.
module tb_tsr_wr_ingress;

    localparam int IMG_WORDS = 384;
    localparam int IMG_AW    = 9;
    localparam int PIX_W     = 24;
    localparam int WGT_BASE  = 3097;
    localparam int WGT_WORDS = 14173;
    localparam int WGT_AW    = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              axi_wr_en;
    logic [19:0]       axi_wr_addr;
    logic [63:0]       axi_wr_data;
    logic [7:0]        axi_wr_strobe;
    logic              wgt_we;
    logic [WGT_AW-1:0] wgt_addr;
    logic [63:0]       wgt_data;
    logic              weight_load_done;
    logic              frm_valid;
    logic              frm_rd_en;
    logic [IMG_AW-1:0] frm_rd_addr;
    logic [PIX_W-1:0]  frm_rd_data;
    logic              frm_done;
    logic              err_drop;

    tsr_wr_ingress #(
        .IMG_WORDS(IMG_WORDS), .IMG_AW(IMG_AW), .PIX_W(PIX_W),
        .WGT_BASE(WGT_BASE), .WGT_WORDS(WGT_WORDS), .WGT_AW(WGT_AW)
    ) dut (
        .clk(clk), .rst(rst),
        .axi_wr_en(axi_wr_en), .axi_wr_addr(axi_wr_addr),
        .axi_wr_data(axi_wr_data), .axi_wr_strobe(axi_wr_strobe),
        .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .weight_load_done(weight_load_done), .frm_valid(frm_valid),
        .frm_rd_en(frm_rd_en), .frm_rd_addr(frm_rd_addr), .frm_rd_data(frm_rd_data),
        .frm_done(frm_done), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WGT_AW-1:0] addr;
        logic [63:0]       data;
    } wgt_exp_t;

    wgt_exp_t         wq[$];
    logic [PIX_W-1:0] rq[$];
    wgt_exp_t         mon_e;
    logic [PIX_W-1:0] mon_p;
    logic             rd_pend = 1'b0;
    int               n_vec = 0;
    int               n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [63:0] ref_mask(input logic [63:0] d, input logic [7:0] s);
        logic [63:0] mk;
        for (int k = 0; k < 8; k++) mk[8*k +: 8] = {8{s[k]}};
        return d & mk;
    endfunction

    function automatic logic [63:0] pix_data(input int f, input int i);
        return 64'hFFEE_DDCC_BB00_0000 | (64'(f) << 16) | 64'(i);
    endfunction

    function automatic logic [PIX_W-1:0] exp_pix(input int f, input int i);
        return {8'(f), 16'(i)};
    endfunction

    always @(posedge clk) rd_pend <= frm_rd_en;

    always @(negedge clk) begin
        if (wgt_we) begin
            if (wq.size() == 0) begin
                check_val("wgt_unexpected", 128'(wgt_we), 128'd0);
            end else begin
                mon_e = wq.pop_front();
                check_val("wgt_addr", 128'(wgt_addr), 128'(mon_e.addr));
                check_val("wgt_data", 128'(wgt_data), 128'(mon_e.data));
            end
        end
        if (rd_pend) begin
            if (rq.size() == 0) begin
                check_val("rd_unexpected", 128'(rd_pend), 128'd0);
            end else begin
                mon_p = rq.pop_front();
                check_val("rd_data", 128'(frm_rd_data), 128'(mon_p));
            end
        end
    end

    task automatic drive(input logic en, input logic [19:0] a, input logic [63:0] d, input logic [7:0] s,
                         input logic dn, input logic ren, input logic [IMG_AW-1:0] ra);
        @(posedge clk); #1;
        axi_wr_en = en; axi_wr_addr = a; axi_wr_data = d; axi_wr_strobe = s;
        frm_done = dn; frm_rd_en = ren; frm_rd_addr = ra;
    endtask

    task automatic idle();
        drive(1'b0, 20'd0, 64'd0, 8'h00, 1'b0, 1'b0, '0);
    endtask

    task automatic beat_dn(input int a, input logic [63:0] d, input logic [7:0] s, input logic dn);
        drive(1'b1, 20'(a), d, s, dn, 1'b0, '0);
        if (s != 8'h00 && a >= WGT_BASE && a < WGT_BASE + WGT_WORDS)
            wq.push_back({WGT_AW'(a - WGT_BASE), ref_mask(d, s)});
    endtask

    task automatic beat(input int a, input logic [63:0] d, input logic [7:0] s);
        beat_dn(a, d, s, 1'b0);
    endtask

    task automatic rd(input int a, input logic [PIX_W-1:0] want);
        drive(1'b0, 20'd0, 64'd0, 8'h00, 1'b0, 1'b1, IMG_AW'(a));
        rq.push_back(want);
        idle();
    endtask

    task automatic release_frame();
        drive(1'b0, 20'd0, 64'd0, 8'h00, 1'b1, 1'b0, '0);
        idle();
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic load_weights();
        for (int i = 0; i < WGT_WORDS; i++) beat(WGT_BASE + i, 64'hAABB_CCDD_EEFF_1234, 8'h03);
        idle();
    endtask

    // Leaves the last beat on the bus; caller observes before and after its capture edge.
    task automatic send_frame(input int f, input logic dn_last);
        for (int i = 0; i < IMG_WORDS - 1; i++) beat(i, pix_data(f, i), 8'h07);
        beat_dn(IMG_WORDS - 1, pix_data(f, IMG_WORDS - 1), 8'h07, dn_last);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; axi_wr_en = 1'b0; axi_wr_addr = 20'd0; axi_wr_data = 64'd0; axi_wr_strobe = 8'h00;
        frm_done = 1'b0; frm_rd_en = 1'b0; frm_rd_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_wgt_we", 128'(wgt_we), 128'd0);
        check_val("rst_done", 128'(weight_load_done), 128'd0);
        check_val("rst_frm_valid", 128'(frm_valid), 128'd0);
        check_val("rst_err", 128'(err_drop), 128'd0);
        check_val("rst_rd_data", 128'(frm_rd_data), 128'd0);

        // image beat before weights are loaded
        beat(10, pix_data(0, 10), 8'h07);
        idle();
        @(negedge clk);
        check_val("early_img_err", 128'(err_drop), 128'd1);
        check_val("early_img_fv", 128'(frm_valid), 128'd0);
        pulse_rst();
        @(negedge clk);
        check_val("rst2_err", 128'(err_drop), 128'd0);

        load_weights();
        @(negedge clk);
        check_val("wdone_lat", 128'(weight_load_done), 128'd0);
        @(negedge clk);
        check_val("wdone", 128'(weight_load_done), 128'd1);
        check_val("wload_err", 128'(err_drop), 128'd0);
        check_val("wq_drained", 128'(wq.size()), 128'd0);

        // reload after done is forwarded; empty-strobe beats are ignored
        beat(WGT_BASE + 7, 64'h1122_3344_5566_7788, 8'hF0);
        beat(0, 64'h1234, 8'h00);
        beat(WGT_BASE, 64'h1234, 8'h00);
        idle();
        @(negedge clk);
        @(negedge clk);
        check_val("reload_done", 128'(weight_load_done), 128'd1);
        check_val("strb0_err", 128'(err_drop), 128'd0);

        send_frame(0, 1'b0);
        @(negedge clk);
        check_val("fv_early", 128'(frm_valid), 128'd0);
        idle();
        @(negedge clk);
        check_val("fv_rise", 128'(frm_valid), 128'd1);
        rd(5, 24'h000005);
        rd(0, exp_pix(0, 0));
        rd(383, exp_pix(0, 383));

        send_frame(1, 1'b0);
        idle();
        @(negedge clk);
        check_val("f2_err", 128'(err_drop), 128'd0);
        check_val("f2_fv", 128'(frm_valid), 128'd1);
        rd(5, exp_pix(0, 5));

        send_frame(2, 1'b0);
        idle();
        @(negedge clk);
        check_val("f3_drop_err", 128'(err_drop), 128'd1);

        release_frame();
        @(negedge clk);
        check_val("fv_after_done", 128'(frm_valid), 128'd1);
        rd(5, exp_pix(1, 5));
        rd(100, exp_pix(1, 100));

        // final beat into bank 0 coincides with releasing bank 1
        send_frame(3, 1'b1);
        idle();
        @(negedge clk);
        check_val("fv_swap", 128'(frm_valid), 128'd1);
        rd(5, exp_pix(3, 5));
        release_frame();
        @(negedge clk);
        check_val("fv_drained", 128'(frm_valid), 128'd0);

        for (int i = 0; i < 200; i++) beat(i, pix_data(4, i), 8'h07);
        idle();
        pulse_rst();
        @(negedge clk);
        check_val("mid_rst_fv", 128'(frm_valid), 128'd0);
        check_val("mid_rst_done", 128'(weight_load_done), 128'd0);
        check_val("mid_rst_err", 128'(err_drop), 128'd0);

        load_weights();
        @(negedge clk);
        @(negedge clk);
        check_val("wdone2", 128'(weight_load_done), 128'd1);
        send_frame(5, 1'b0);
        @(negedge clk);
        check_val("fv_early2", 128'(frm_valid), 128'd0);
        idle();
        @(negedge clk);
        check_val("fv_rise2", 128'(frm_valid), 128'd1);
        rd(7, exp_pix(5, 7));
        release_frame();
        @(negedge clk);
        check_val("one_frame", 128'(frm_valid), 128'd0);

        beat(500, 64'h0123_4567_89AB_CDEF, 8'hFF);
        idle();
        @(negedge clk);
        check_val("drop_gap_err", 128'(err_drop), 128'd1);
        beat(WGT_BASE - 1, 64'h55, 8'hFF);
        beat(WGT_BASE + WGT_WORDS, 64'h66, 8'hFF);
        beat(IMG_WORDS, 64'h77, 8'hFF);
        repeat (3) idle();
        @(negedge clk);
        check_val("edge_fv", 128'(frm_valid), 128'd0);
        check_val("end_wq", 128'(wq.size()), 128'd0);
        check_val("end_rq", 128'(rq.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tsr_wr_ingress.md
Name: tsr_wr_ingress

Overview:
Receive-side endpoint of the 20-bit-address / 64-bit-data write bus that loads the TSR accelerator. Decodes each write beat into one of two paths. Weight beats are forwarded to the weight memory port. Image beats are stored in a two-bank ping-pong frame buffer that the CNN datapath reads. Generates weight_load_done and per-frame ready/release handshakes; the bus has no backpressure.

Parameters:
IMG_WORDS, 384, beats per input frame (addresses 0..IMG_WORDS-1)
IMG_AW, 9, frame buffer address width
PIX_W, 24, stored pixel width (byte lanes 0..2)
WGT_BASE, 3097, first weight address
WGT_WORDS, 14173, number of weight beats
WGT_AW, 14, weight memory address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
axi_wr_en  in  1  write beat valid this cycle
axi_wr_addr  in  20  beat address
axi_wr_data  in  64  beat data
axi_wr_strobe  in  8  byte-lane enables
wgt_we  out  1  weight memory write enable
wgt_addr  out  WGT_AW  axi_wr_addr - WGT_BASE
wgt_data  out  64  strobe-masked data
weight_load_done  out  1  all weight beats received (sticky)
frm_valid  out  1  a full frame is ready in the read bank
frm_rd_en  in  1  consumer read strobe
frm_rd_addr  in  IMG_AW  consumer read address
frm_rd_data  out  PIX_W  read data, 1-cycle latency
frm_done  in  1  one-cycle pulse: consumer releases read bank
err_drop  out  1  sticky: a beat was dropped

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. On reset all outputs go to 0, counters clear, both banks are EMPTY, write bank = 0, read bank = 0. Buffer RAM contents are not cleared.
- Masking: byte lane k = axi_wr_data[8k+7:8k] if axi_wr_strobe[k], else 0. A beat with strobe == 0 is ignored (no count, no error).
- Decode on axi_wr_en=1:
  - WGT: WGT_BASE <= addr < WGT_BASE+WGT_WORDS.
  - IMG: addr < IMG_WORDS.
  - Anything else: drop and set err_drop.
- Weight path: wgt_we/wgt_addr/wgt_data are registered, 1-cycle latency. wgt_cnt increments per accepted WGT beat. weight_load_done rises the cycle after wgt_cnt reaches WGT_WORDS and stays high until rst. WGT beats after done are still forwarded (reload allowed); the counter saturates.
- Image path:
  - An IMG beat before weight_load_done is dropped and sets err_drop.
  - Otherwise, if the write bank is not FULL, pixel bytes [PIX_W-1:0] are written at the beat address and img_cnt increments.
  - When img_cnt reaches IMG_WORDS, the bank becomes FULL, img_cnt clears, and the write bank toggles.
  - If the write bank is FULL (both banks full), the beat is dropped and err_drop is set.
- Bank states per bank: EMPTY -> FILLING (first beat) -> FULL (IMG_WORDS beats) -> READING (selected by read side) -> EMPTY (on frm_done).
- frm_valid = 1 while the read bank is FULL or READING; it rises the cycle after the last beat is written.
- On frm_done, the read bank returns to EMPTY and the read pointer toggles. frm_done while frm_valid=0 is ignored.
- Same-cycle final beat and frm_done on the other bank: both take effect. frm_valid stays 1 with the new bank next cycle.
- frm_rd_data is registered from the current read bank. The read address is not bounds-checked; out-of-range reads return don't-care.
- rst mid-frame discards the partial frame and any pending frames.

Optional Feature:
WR_SEQ_CHECK_EN:
- Defined: IMG beats must arrive in order, addr == img_cnt. An out-of-order beat is dropped, sets err_drop, and does not advance img_cnt. WGT beats must satisfy addr == WGT_BASE + wgt_cnt until done; out-of-order WGT beats are dropped with err_drop.
- Undefined: any in-range address is accepted, and the counters count beats regardless of address (duplicates count).

Test Plan:
- Reset, then WGT_WORDS sequential beats at addr 3097.., strobe 8'h03, data 64'hAABB_CCDD_EEFF_1234 -> wgt_data 64'h0000_0000_0000_1234 one cycle later, wgt_addr 0..14172, weight_load_done=1 after the last beat, err_drop=0.
- After done, 384 beats at addr 0..383, strobe 8'h07, data = addr -> frm_valid=1 the cycle after the last beat; frm_rd_addr 5 returns 24'h000005 the next cycle.
- IMG beat at addr 10 before weight_load_done -> no write, err_drop=1, frm_valid stays 0.
- Three back-to-back frames without frm_done -> frames 1 and 2 fill banks 0 and 1; frame 3 beats dropped and err_drop=1. After frm_done, frm_valid stays 1 with bank 1 data.
- Write to addr 500 (between image and weight regions) -> dropped, err_drop=1. Beat with strobe 8'h00 at addr 0 -> ignored, img_cnt unchanged.
- rst asserted after 200 image beats -> frm_valid=0, weight_load_done=0, the next 384 beats after a weight reload produce exactly one frame.
